// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for an N-register in-order core.
// Turns per-register stall/flush requests into the en/zero inputs of every
// pipeline register, drains the pipe behind a halt instruction and keeps
// saturating performance counters.
//
// Ports:
//   CLK, nRST        clock; synchronous active-high reset
//   stall_req        per-register hold request (bit 0 = youngest)
//   flush_req        per-register bubble request
//   halt_req         register HALT_REG holds a halt instruction
//   en, zero         per-register load enable / clear (zero dominates)
//   halt             core halted, sticky until reset
//   cycle_cnt        RUN/DRAIN cycles
//   stall_cnt        RUN/DRAIN cycles with any stall request
//   flush_cnt        RUN/DRAIN cycles with any flush request
//
// state  | meaning
// RUN    | normal operation
// DRAIN  | halt travelling toward the oldest register, younger work discarded
// HALTED | halt retired; outputs quiet, counters frozen
module pipe_ctrl #(
  parameter int STAGES   = 4,
  parameter int HALT_REG = 0,
  parameter int CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  input  logic              halt_req,
  output logic [STAGES-1:0] en,
  output logic [STAGES-1:0] zero,
  output logic              halt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int PW = (STAGES > 2) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic            halt_q, halt_d;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

  logic            active;
  logic            drain;
  logic            stall_any;
  logic            flush_any;
  logic [PW-1:0]   p;
  int              h;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    halt_d    = halt_q;
    en        = '0;
    zero      = '0;
    active    = 1'b0;
    drain     = 1'b0;
    p         = '0;
    stall_any = 1'b0;
    flush_any = |flush_req;
    h         = 0;

    // highest stalled register; everything younger must also hold
    for (int i = 0; i < STAGES; i++) begin
      if (stall_req[i]) begin
        stall_any = 1'b1;
        h         = i;
      end
    end

    if (nRST) begin
      en   = '0;
      zero = '1;
    end else if (state_q != HALTED) begin
      active = 1'b1;
      for (int j = 0; j < STAGES; j++) begin
        en[j] = !stall_any || (j > h);
        if (stall_any && (j == h + 1)) zero[j] = 1'b1;
      end
      zero = zero | flush_req;

      // the RUN cycle that sees a valid halt already behaves as a drain cycle
      if (state_q == DRAIN) begin
        drain = 1'b1;
        p     = pos_q;
      end else if (halt_req && !flush_req[HALT_REG]) begin
        drain = 1'b1;
        p     = PW'(HALT_REG);
      end

      if (drain) begin
        for (int i = 0; i < STAGES; i++) begin
          if (i < int'(p)) zero[i] = 1'b1;
          else if ((i == int'(p)) && en[i]) zero[i] = 1'b1;
        end

        if ((state_q == DRAIN) && flush_req[p]) begin
          // halt was on a wrong path
          state_d = RUN;
        end else if (p == PW'(STAGES - 1)) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end else begin
          state_d = DRAIN;
          pos_d   = en[p] ? p + 1'b1 : p;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= RUN;
      pos_q   <= '0;
      halt_q  <= 1'b0;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      halt_q  <= halt_d;
      if (active) begin
        if (cycle_q != '1)              cycle_q <= cycle_q + 1'b1;
        if (stall_any && stall_q != '1) stall_q <= stall_q + 1'b1;
        if (flush_any && flush_q != '1) flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign halt      = halt_q;
  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STAGES=4, HALT_REG=0). A second instance
// with 2-bit counters shares the stimulus to exercise counter saturation.
module tb_pipe_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [3:0] stall_req, flush_req;
  logic       halt_req;
  logic [3:0] en, zero;
  logic       halt;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [3:0] en2, zero2;
  logic       halt2;
  logic [1:0] cyc2, stl2, fl2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  pipe_ctrl #(.STAGES(4), .HALT_REG(0), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .stall_req(stall_req), .flush_req(flush_req),
    .halt_req(halt_req), .en(en), .zero(zero), .halt(halt),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.STAGES(4), .HALT_REG(0), .CNT_W(2)) dut_sat (
    .CLK(CLK), .nRST(nRST), .stall_req(stall_req), .flush_req(flush_req),
    .halt_req(halt_req), .en(en2), .zero(zero2), .halt(halt2),
    .cycle_cnt(cyc2), .stall_cnt(stl2), .flush_cnt(fl2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b1; stall_req = '0; flush_req = '0; halt_req = 1'b0;
    tick();
    nRST = 1'b0;
    #1;
  endtask

  initial begin
    nRST = 1'b1; stall_req = '0; flush_req = '0; halt_req = 1'b0;
    #1;
    check_val("rst_en", en, 4'b0000);
    check_val("rst_zero", zero, 4'b1111);
    tick(); tick();
    check_val("rst_cycle", cycle_cnt, 0);
    check_val("rst_stall", stall_cnt, 0);
    check_val("rst_flush", flush_cnt, 0);
    check_val("rst_halt", halt, 0);
    nRST = 1'b0;
    #1;
    check_val("run_en", en, 4'b1111);
    check_val("run_zero", zero, 4'b0000);
    tick();
    check_val("cycle_first", cycle_cnt, 1);

    // stall on oldest register freezes everything
    stall_req = 4'b1000;
    #1;
    check_val("stall3_en", en, 4'b0000);
    check_val("stall3_zero", zero, 4'b0000);
    tick(); tick(); tick();
    check_val("stall3_cnt", stall_cnt, 3);
    stall_req = 4'b0010;
    #1;
    check_val("stall1_en", en, 4'b1100);
    check_val("stall1_zero", zero, 4'b0100);
    tick();
    check_val("stall1_cnt", stall_cnt, 4);
    check_val("cycle_5", cycle_cnt, 5);
    check_val("sat_cycle", cyc2, 3);

    // flush beats stall on the same register
    stall_req = 4'b0001; flush_req = 4'b0011;
    #1;
    check_val("sf_en", en, 4'b1110);
    check_val("sf_zero", zero, 4'b0011);
    tick();
    check_val("sf_flush_cnt", flush_cnt, 1);
    check_val("sf_stall_cnt", stall_cnt, 5);
    check_val("sat_stall", stl2, 3);
    check_val("sat_flush", fl2, 1);
    stall_req = '0; flush_req = '0;

    // plain halt drain
    halt_req = 1'b1;
    #1;
    check_val("h_entry_zero", zero, 4'b0001);
    check_val("h_entry_en", en, 4'b1111);
    tick();
    halt_req = 1'b0;
    #1;
    check_val("h_pos1_zero", zero, 4'b0011);
    tick();
    check_val("h_pos2_zero", zero, 4'b0111);
    check_val("h_pos2_halt", halt, 0);
    tick();
    check_val("h_pos3_zero", zero, 4'b1111);
    check_val("h_pos3_halt", halt, 0);
    tick();
    check_val("h_halt", halt, 1);
    check_val("h_en", en, 4'b0000);
    check_val("h_zero", zero, 4'b0000);
    check_val("h_cycle", cycle_cnt, 10);
    stall_req = 4'b1111; flush_req = 4'b1111; halt_req = 1'b1;
    #1;
    check_val("hz_en", en, 4'b0000);
    check_val("hz_zero", zero, 4'b0000);
    tick(); tick();
    check_val("hz_cycle", cycle_cnt, 10);
    check_val("hz_stall", stall_cnt, 5);
    check_val("hz_flush", flush_cnt, 1);
    check_val("hz_halt", halt, 1);

    // halt drain with a 2-cycle stall at pos=2
    do_reset();
    check_val("r2_cycle", cycle_cnt, 0);
    check_val("r2_halt", halt, 0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    stall_req = 4'b1000;
    #1;
    check_val("hs_en", en, 4'b0000);
    check_val("hs_zero", zero, 4'b0011);
    tick();
    check_val("hs_zero_hold", zero, 4'b0011);
    tick();
    stall_req = '0;
    #1;
    check_val("hs_pos2_zero", zero, 4'b0111);
    check_val("hs_pos2_halt", halt, 0);
    tick();
    check_val("hs_pos3_zero", zero, 4'b1111);
    check_val("hs_pos3_halt", halt, 0);
    tick();
    check_val("hs_halt", halt, 1);
    check_val("hs_cycle", cycle_cnt, 6);
    check_val("hs_stall", stall_cnt, 2);

    // wrong-path halt cancelled by flush
    do_reset();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    flush_req = 4'b0010;
    #1;
    check_val("hf_zero", zero, 4'b0011);
    tick();
    flush_req = '0;
    #1;
    check_val("hf_run_zero", zero, 4'b0000);
    check_val("hf_run_en", en, 4'b1111);
    tick(); tick(); tick();
    check_val("hf_no_halt", halt, 0);
    check_val("hf_run_zero2", zero, 4'b0000);
    halt_req = 1'b1;
    #1;
    check_val("hf_re_entry", zero, 4'b0001);
    tick();
    halt_req = 1'b0;
    #1;
    check_val("hf_re_pos1", zero, 4'b0011);

    // halt and flush on HALT_REG together stays in RUN
    do_reset();
    halt_req = 1'b1; flush_req = 4'b0001;
    #1;
    check_val("hx_zero", zero, 4'b0001);
    tick();
    halt_req = 1'b0; flush_req = '0;
    #1;
    check_val("hx_run_zero", zero, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline sequencer for the N-register in-order core.
- Replaces the fixed stall/squash glue with a generic per-register enable/zero generator. Enables are driven by per-register stall requests and zeros by per-register flush requests.
- Adds a halt-drain FSM: younger instructions are discarded and the pipeline drains until the halt instruction retires.
- Provides saturating performance counters.
- Sits beside the hazard, branch and forward units and drives every pipeline register's en/zero inputs.

Parameters:
- STAGES, 4, number of pipeline registers. Index 0 is youngest (fetch/decode); STAGES-1 is oldest (mem/wb). Must be ≥2.
- HALT_REG, 0, index of the register whose contents halt_req describes. Must be < STAGES-1.
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset. One clock; reset is synchronous and active-high (reset when nRST=1).
- stall_req  in  STAGES  bit i=1: register i must hold its contents this cycle.
- flush_req  in  STAGES  bit i=1: register i loads a bubble at the next edge.
- halt_req  in  1  the instruction in register HALT_REG is a halt.
- en  out  STAGES  load enable of register i.
- zero  out  STAGES  clear of register i. zero has priority over en.
- halt  out  1  core halted; sticky until reset.
- cycle_cnt  out  CNT_W  cycles spent in RUN or DRAIN.
- stall_cnt  out  CNT_W  cycles with any stall_req bit set (RUN/DRAIN only).
- flush_cnt  out  CNT_W  cycles with any flush_req bit set (RUN/DRAIN only).

Behaviour:
- Register semantics at each edge: if zero[i], register i loads a bubble; else if en[i], it loads; else it holds.
- Reset (nRST=1 at an edge):
  - state=RUN, pos=0, halt=0, all counters 0.
  - While nRST=1, outputs are combinationally en=0 and zero=all ones.
- Stall rule (RUN/DRAIN), combinational:
  - h = highest i with stall_req[i].
  - en[j]=0 for all j≤h; en[j]=1 for j>h.
  - If h<STAGES-1, then zero[h+1]=1 (bubble inserted behind the stall).
  - No stall: en=all ones.
- Flush rule: zero[i]|=flush_req[i], even when register i is stalled.
- FSM states: RUN, DRAIN, HALTED. pos = index of the register holding the halt instruction.
- RUN:
  - If halt_req && !flush_req[HALT_REG], the current cycle acts as a DRAIN cycle with p=HALT_REG.
  - Next state is DRAIN, with pos_next = en[HALT_REG] ? HALT_REG+1 : HALT_REG.
- DRAIN (p = pos):
  - zero[i]=1 for all i<p.
  - zero[p]=en[p]: the halt moves forward and a bubble replaces it.
  - If flush_req[p]=1, the halt was on a wrong path. Next state is RUN and the zero overrides end the next cycle.
  - Else if p==STAGES-1, next state is HALTED (the final stage consumes the halt this cycle).
  - Else pos_next = en[p] ? p+1 : p.
  - halt_req is ignored while in DRAIN.
- HALTED:
  - en=0, zero=0, halt=1.
  - Counters are frozen and stall_req, flush_req and halt_req are ignored.
  - Only reset exits HALTED.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at 2^CNT_W-1 (no wrap).
  - cycle_cnt counts every RUN/DRAIN cycle, including the entry cycle.
  - Counter updates are registered: a value is visible the cycle after the event.
- Simultaneous events:
  - Stall and flush on the same register: the flush wins (zero=1, en=0).
  - A stall at p in DRAIN holds the halt in place: pos is unchanged and DRAIN is extended by one cycle per stalled cycle.
  - halt_req and flush_req[HALT_REG] in the same cycle: stay in RUN.
- Latency: en/zero are combinational from their inputs. State, pos, halt and counters are registered.

Test Plan:
- Hold nRST=1 for 2 cycles, then 0 → en=0000 and zero=1111 during reset. After release: en=1111, zero=0000, halt=0, all counters 0, and cycle_cnt=1 one cycle after the first RUN cycle.
- stall_req=1000 for 3 cycles, then 0010 for 1 cycle → first: en=0000, zero=0000, stall_cnt=3. Then: en=1100, zero=0100, stall_cnt=4.
- stall_req=0001 with flush_req=0011 → en=1110, zero=0011, flush_cnt increments by 1, stall_cnt increments by 1.
- halt_req for 1 cycle with no stalls (STAGES=4, HALT_REG=0):
  - Entry cycle zero=0001; state DRAIN with pos=1, 2, 3 on successive edges.
  - halt=1 on the 4th edge after halt_req; en=0000 thereafter.
  - cycle_cnt stops advancing; later stall_req/flush_req inputs leave the counters unchanged.
- Same as above, but stall_req=1000 for 2 cycles while pos=2 → pos holds at 2 and halt rises 2 cycles later than without the stall.
- halt_req, then flush_req=0010 while pos=1 → return to RUN, halt stays 0, zero=0000 on the next cycle, and a later halt_req restarts the drain.
